// File: rtl/surf_cmd_defs.sv
// Shared definitions for the SURF command scheduler: sizes, command record,
// dispatcher state encoding and the free-buffer priority encoder.
package surf_cmd_defs;

  localparam int NUM_BUFFERS   = 4;
  localparam int BUF_IDX_BITS  = 2;
  localparam int EVENT_ID_BITS = 32;
  localparam int CMD_BITS      = EVENT_ID_BITS + BUF_IDX_BITS;
  localparam int DONE_TIMEOUT  = 1023;
  localparam int TIMER_BITS    = 10;
  localparam int DROP_CNT_BITS = 16;
  // Holds 0..NUM_BUFFERS+1 (full queue plus one in flight).
  localparam int PEND_BITS     = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [EVENT_ID_BITS-1:0] event_id;
    logic [BUF_IDX_BITS-1:0]  buffer;
  } cmd_t;

  // Lowest-index clear bit of the busy mask; returns 0 when all are set,
  // so callers must qualify the result with a separate "any free" test.
  function automatic logic [BUF_IDX_BITS-1:0] first_free(
    input logic [NUM_BUFFERS-1:0] mask
  );
    logic [BUF_IDX_BITS-1:0] idx;
    idx = '0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      if (!mask[i]) idx = BUF_IDX_BITS'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/surf_cmd_fifo.sv
// Four-entry first-word-fall-through command queue with occupancy count.
// head_o is valid whenever empty_o is low; a pop consumes it at the edge.
// Push into a full queue and pop from an empty queue are ignored.
module surf_cmd_fifo
  import surf_cmd_defs::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 push_i,
  input  cmd_t                 push_data_i,
  input  logic                 pop_i,
  output cmd_t                 head_o,
  output logic                 empty_o,
  output logic [PEND_BITS-1:0] count_o
);

  cmd_t                    mem [NUM_BUFFERS];
  logic [BUF_IDX_BITS-1:0] wr_ptr_q;
  logic [BUF_IDX_BITS-1:0] rd_ptr_q;
  logic [PEND_BITS-1:0]    count_q;
  logic                    do_push;
  logic                    do_pop;

  assign do_push = push_i && (count_q != PEND_BITS'(NUM_BUFFERS));
  assign do_pop  = pop_i && (count_q != '0);

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep the count.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/surf_cmd_scheduler.sv
// SURF command scheduler: allocates a digitizer buffer per trigger, queues
// {event_id, buffer} commands and dispatches them one at a time to the
// serializer.
// Serializer handshake: cmd_start_o is a one-cycle pulse that launches the
// command shown on cmd_event_id_o/cmd_buffer_o; those stay stable until the
// command retires on a cmd_done_i pulse (or on timeout). cmd_done_i outside
// WAIT_DONE has no effect and start is never retried.
module surf_cmd_scheduler
  import surf_cmd_defs::*;
(
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     trig_i,
  input  logic [EVENT_ID_BITS-1:0] trig_event_id_i,
  output logic                     trig_accepted_o,
  output logic                     trig_dropped_o,
  input  logic [NUM_BUFFERS-1:0]   buffer_release_i,
  output logic                     cmd_start_o,
  output logic [EVENT_ID_BITS-1:0] cmd_event_id_o,
  output logic [BUF_IDX_BITS-1:0]  cmd_buffer_o,
  input  logic                     cmd_done_i,
  output logic [NUM_BUFFERS-1:0]   buffers_busy_o,
  output logic [PEND_BITS-1:0]     pending_o,
  output logic [DROP_CNT_BITS-1:0] dropped_count_o,
  output logic                     timeout_err_o
);

  sched_state_t             state_q;
  sched_state_t             state_d;
  logic [NUM_BUFFERS-1:0]   busy_q;
  logic [TIMER_BITS-1:0]    timer_q;
  logic [DROP_CNT_BITS-1:0] drop_cnt_q;
  logic                     timeout_err_q;
  logic                     cmd_start_q;
  cmd_t                     cmd_q;
  logic                     trig_acc_q;
  logic                     trig_drop_q;

  cmd_t                     fifo_head;
  cmd_t                     push_cmd;
  logic                     fifo_empty;
  logic [PEND_BITS-1:0]     fifo_count;
  logic                     fifo_pop;
  logic                     timer_clr;
  logic                     timeout_hit;

  logic                     has_free;
  logic                     queue_full;
  logic                     accept;
  logic                     drop;
  logic [BUF_IDX_BITS-1:0]  alloc_idx;
  logic [NUM_BUFFERS-1:0]   alloc_bit;

  // Allocation works on the registered (pre-release) mask. A queue-full
  // guard covers the case where releases of still-queued buffers let more
  // triggers in than the queue can hold; such triggers are dropped.
  always_comb begin
    has_free   = ~&busy_q;
    queue_full = (fifo_count == PEND_BITS'(NUM_BUFFERS));
    alloc_idx  = first_free(busy_q);
    accept     = trig_i && has_free && !queue_full;
    drop       = trig_i && !accept;
    alloc_bit  = '0;
    if (accept) alloc_bit = NUM_BUFFERS'(1) << alloc_idx;
    push_cmd   = '{event_id: trig_event_id_i, buffer: alloc_idx};
  end

  surf_cmd_fifo u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (accept),
    .push_data_i (push_cmd),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Dispatcher state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Dispatcher next state; done wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (cmd_done_i)                                     state_d = ST_IDLE;
        else if (timer_q == TIMER_BITS'(DONE_TIMEOUT - 1)) state_d = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // Dispatcher outputs: pop on leaving IDLE, timer clear in ISSUE, and the
  // timeout event on the last allowed WAIT_DONE cycle (the timer counts the
  // WAIT_DONE cycles already spent, so 1022 here is the 1023rd cycle).
  always_comb begin
    fifo_pop    = (state_q == ST_IDLE) && !fifo_empty;
    timer_clr   = (state_q == ST_ISSUE);
    timeout_hit = (state_q == ST_WAIT_DONE) && !cmd_done_i &&
                  (timer_q == TIMER_BITS'(DONE_TIMEOUT - 1));
  end

  // Registered command outputs, wait timer and sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cmd_start_q   <= 1'b0;
      cmd_q         <= '0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cmd_start_q <= fifo_pop;
      if (fifo_pop) cmd_q <= fifo_head;
      if (timer_clr)                       timer_q <= '0;
      else if (state_q == ST_WAIT_DONE)    timer_q <= timer_q + 1'b1;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  // Busy mask, trigger status pulses and saturating drop counter. A freshly
  // allocated bit cannot collide with a release because release of a clear
  // bit has no effect.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      busy_q      <= '0;
      trig_acc_q  <= 1'b0;
      trig_drop_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      busy_q      <= (busy_q & ~buffer_release_i) | alloc_bit;
      trig_acc_q  <= accept;
      trig_drop_q <= drop;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign trig_accepted_o = trig_acc_q;
  assign trig_dropped_o  = trig_drop_q;
  assign cmd_start_o     = cmd_start_q;
  assign cmd_event_id_o  = cmd_q.event_id;
  assign cmd_buffer_o    = cmd_q.buffer;
  assign buffers_busy_o  = busy_q;
  assign pending_o       = fifo_count + PEND_BITS'(state_q != ST_IDLE);
  assign dropped_count_o = drop_cnt_q;
  assign timeout_err_o   = timeout_err_q;

endmodule

// File: tb/tb_surf_cmd_scheduler.sv
// Directed bench for surf_cmd_scheduler: reset, latency, allocation order,
// drop, release/alloc collision, timeout retire, mid-command reset and
// drop-counter saturation. Issued commands are checked against exp_q.
module tb_surf_cmd_scheduler;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic [31:0] trig_id;
  logic        trig_acc;
  logic        trig_drop;
  logic [3:0]  release_v;
  logic        cmd_start;
  logic [31:0] cmd_id;
  logic [1:0]  cmd_buf;
  logic        cmd_done;
  logic [3:0]  busy;
  logic [2:0]  pending;
  logic [15:0] drop_cnt;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  surf_cmd_scheduler dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .trig_i           (trig),
    .trig_event_id_i  (trig_id),
    .trig_accepted_o  (trig_acc),
    .trig_dropped_o   (trig_drop),
    .buffer_release_i (release_v),
    .cmd_start_o      (cmd_start),
    .cmd_event_id_o   (cmd_id),
    .cmd_buffer_o     (cmd_buf),
    .cmd_done_i       (cmd_done),
    .buffers_busy_o   (busy),
    .pending_o        (pending),
    .dropped_count_o  (drop_cnt),
    .timeout_err_o    (timeout_err)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Driver helpers
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Retire the in-flight command; the next one must start exactly at done+2.
  task automatic pulse_done(input logic expect_next);
    cmd_done = 1'b1;
    cyc(1);
    cmd_done = 1'b0;
    check("start_not_early", 64'(cmd_start), 64'(1'b0));
    cyc(1);
    check("start_at_done_plus_2", 64'(cmd_start), 64'(expect_next));
  endtask

  // Scoreboard: every start must match the oldest expected command.
  always @(negedge clk) begin
    if (rst_n && cmd_start) begin
      if (exp_q.size() == 0) begin
        check("unexpected_start", 64'(1'b1), 64'(1'b0));
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("start_cmd", 64'({cmd_id, cmd_buf}), 64'(e));
      end
    end
  end

  initial begin
    rst_n = 1'b0; trig = 1'b0; trig_id = '0; release_v = '0; cmd_done = 1'b0;
    cyc(2);
    check("rst_busy", 64'(busy), 64'(4'b0000));
    check("rst_pending", 64'(pending), 64'(3'd0));
    check("rst_start", 64'(cmd_start), 64'(1'b0));
    check("rst_id", 64'(cmd_id), 64'(32'h0));
    check("rst_drop_cnt", 64'(drop_cnt), 64'(16'h0));
    check("rst_timeout", 64'(timeout_err), 64'(1'b0));
    check("rst_acc", 64'(trig_acc), 64'(1'b0));

    // 1: single trigger, start two cycles later, done after 8 cycles
    rst_n = 1'b1;
    trig = 1'b1; trig_id = 32'h01020304;
    exp_q.push_back({32'h01020304, 2'd0});
    cyc(1);
    trig = 1'b0;
    check("t1_accepted", 64'(trig_acc), 64'(1'b1));
    check("t1_busy", 64'(busy), 64'(4'b0001));
    check("t1_start_c1", 64'(cmd_start), 64'(1'b0));
    check("t1_pending_c1", 64'(pending), 64'(3'd1));
    cyc(1);
    check("t1_start_c2", 64'(cmd_start), 64'(1'b1));
    check("t1_buffer", 64'(cmd_buf), 64'(2'd0));
    cyc(1);
    check("t1_start_c3", 64'(cmd_start), 64'(1'b0));
    check("t1_id_stable", 64'(cmd_id), 64'(32'h01020304));
    cyc(7);
    cmd_done = 1'b1;
    cyc(1);
    cmd_done = 1'b0;
    check("t1_pending_done", 64'(pending), 64'(3'd0));
    check("t1_busy_held", 64'(busy), 64'(4'b0001));
    release_v = 4'b0001;
    cyc(1);
    release_v = '0;
    check("t1_busy_released", 64'(busy), 64'(4'b0000));
    check("t1_drained", 64'(exp_q.size()), 64'(0));

    // 2: five triggers back to back, fifth dropped
    for (int i = 1; i <= 5; i++) begin
      trig = 1'b1; trig_id = 32'(i);
      if (i <= 4) exp_q.push_back({32'(i), 2'(i - 1)});
      cyc(1);
      check("t2_accepted", 64'(trig_acc), 64'(i <= 4));
      check("t2_dropped", 64'(trig_drop), 64'(i == 5));
    end
    trig = 1'b0;
    check("t2_busy_full", 64'(busy), 64'(4'b1111));
    check("t2_drop_cnt", 64'(drop_cnt), 64'(16'd1));
    check("t2_pending", 64'(pending), 64'(3'd4));
    cyc(4);
    pulse_done(1'b1);
    cyc(7);
    pulse_done(1'b1);
    cyc(7);
    pulse_done(1'b1);
    cyc(7);
    pulse_done(1'b0);
    check("t2_pending_end", 64'(pending), 64'(3'd0));
    check("t2_drained", 64'(exp_q.size()), 64'(0));

    // 3: release and trigger collide; freed buffer usable next cycle
    trig = 1'b1; trig_id = 32'hAA; release_v = 4'b0100;
    cyc(1);
    trig = 1'b0; release_v = '0;
    check("t3_dropped", 64'(trig_drop), 64'(1'b1));
    check("t3_not_acc", 64'(trig_acc), 64'(1'b0));
    check("t3_busy", 64'(busy), 64'(4'b1011));
    check("t3_drop_cnt", 64'(drop_cnt), 64'(16'd2));
    trig = 1'b1; trig_id = 32'hBB;
    exp_q.push_back({32'hBB, 2'd2});
    cyc(1);
    trig = 1'b0;
    check("t3_accepted", 64'(trig_acc), 64'(1'b1));
    check("t3_busy_full", 64'(busy), 64'(4'b1111));
    cyc(1);
    check("t3_start", 64'(cmd_start), 64'(1'b1));
    check("t3_buffer", 64'(cmd_buf), 64'(2'd2));

    // 4: withhold done; forced retire after 1023 WAIT_DONE cycles
    release_v = 4'b0001;
    cyc(1);
    release_v = '0;
    trig = 1'b1; trig_id = 32'hCC;
    exp_q.push_back({32'hCC, 2'd0});
    cyc(1);
    trig = 1'b0;
    check("t4_busy", 64'(busy), 64'(4'b1111));
    check("t4_pending", 64'(pending), 64'(3'd2));
    cyc(1021);
    check("t4_no_timeout_yet", 64'(timeout_err), 64'(1'b0));
    check("t4_pending_wait", 64'(pending), 64'(3'd2));
    cyc(1);
    check("t4_timeout", 64'(timeout_err), 64'(1'b1));
    check("t4_pending_retired", 64'(pending), 64'(3'd1));
    check("t4_no_start", 64'(cmd_start), 64'(1'b0));
    cyc(1);
    check("t4_next_start", 64'(cmd_start), 64'(1'b1));
    check("t4_timeout_sticky", 64'(timeout_err), 64'(1'b1));
    check("t4_buf2_still_busy", 64'(busy), 64'(4'b1111));

    // 5: reset in WAIT_DONE with three commands pending
    release_v = 4'b1010;
    cyc(1);
    release_v = '0;
    trig = 1'b1; trig_id = 32'hDD;
    exp_q.push_back({32'hDD, 2'd1});
    cyc(1);
    trig_id = 32'hEE;
    exp_q.push_back({32'hEE, 2'd3});
    cyc(1);
    trig = 1'b0;
    check("t5_pending3", 64'(pending), 64'(3'd3));
    rst_n = 1'b0;
    exp_q.delete();
    cyc(1);
    check("t5_busy", 64'(busy), 64'(4'b0000));
    check("t5_pending", 64'(pending), 64'(3'd0));
    check("t5_start", 64'(cmd_start), 64'(1'b0));
    check("t5_timeout_clr", 64'(timeout_err), 64'(1'b0));
    check("t5_drop_cnt_clr", 64'(drop_cnt), 64'(16'd0));
    check("t5_buf_clr", 64'(cmd_buf), 64'(2'd0));
    rst_n = 1'b1; cmd_done = 1'b1;
    cyc(1);
    cmd_done = 1'b0;
    check("t5_late_done_pending", 64'(pending), 64'(3'd0));
    cyc(2);
    check("t5_late_done_start", 64'(cmd_start), 64'(1'b0));

    // 6: fill, then hold trig with the mask full until the counter saturates
    for (int i = 0; i < 4; i++) begin
      trig = 1'b1; trig_id = 32'hF0 + 32'(i);
      exp_q.push_back({32'hF0 + 32'(i), 2'(i)});
      cyc(1);
    end
    check("t6_busy_full", 64'(busy), 64'(4'b1111));
    trig_id = 32'h5A5A5A5A;
    cyc(65534);
    check("t6_drop_cnt_fffe", 64'(drop_cnt), 64'(16'hFFFE));
    cyc(1);
    check("t6_drop_cnt_ffff", 64'(drop_cnt), 64'(16'hFFFF));
    cyc(70000 - 65535);
    check("t6_drop_cnt_sat", 64'(drop_cnt), 64'(16'hFFFF));
    check("t6_drop_pulse", 64'(trig_drop), 64'(1'b1));
    trig = 1'b0;
    cyc(1);
    check("t6_drop_pulse_end", 64'(trig_drop), 64'(1'b0));
    check("t6_timeout", 64'(timeout_err), 64'(1'b1));
    check("t6_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
